// File: rtl/alu_divider_pkg.sv
// alu_divider_pkg: shared state encoding, default width and ALU opcodes for the divider
package alu_divider_pkg;
  localparam int WIDTH_DEF = 16;
  localparam logic [4:0] ALU_DIV_U = 5'h10;
  localparam logic [4:0] ALU_DIV_S = 5'h11;
  typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP, DONE} state_t;
  function automatic logic [4:0] alu_code(input logic is_signed);
    return is_signed ? ALU_DIV_S : ALU_DIV_U;
  endfunction
endpackage

// File: rtl/alu_divider_div_step.sv
// alu_divider_div_step: one restoring shift/trial-subtract step producing one quotient bit
module alu_divider_div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nx,
  output logic             q_bit
);
  logic [WIDTH:0] sh;
  assign sh = {rem, bit_in};
  assign q_bit = sh >= {1'b0, dvs};
  assign rem_nx = q_bit ? WIDTH'(sh - {1'b0, dvs}) : sh[WIDTH-1:0];
endmodule

// File: rtl/alu_divider.sv
// alu_divider: multi-cycle restoring divider, unsigned/signed, truncating, with ALU-style flags
module alu_divider
  import alu_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             zero_out,
  output logic             negative_out,
  output logic             overflow_out,
  output logic             carry_out
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nx;
  logic [4:0] op;
  logic [WIDTH-1:0] a_q, b_q, dq, rem, dvs, rem_nx, q_fin, r_fin, mag_a, mag_b;
  logic [CW-1:0] cnt;
  logic q_bit, sgn, accept, div0, ovf_fin;
  assign sgn = op == ALU_DIV_S;
  assign accept = state == IDLE && start;
  assign div0 = divisor == '0;
  assign carry_out = 1'b0;
  assign mag_a = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
  assign mag_b = (signed_op && divisor[WIDTH-1]) ? -divisor : divisor;
  // In IDLE the only way into DONE is the divide-by-zero bypass, so the live inputs are the result
  assign q_fin = state == IDLE ? '1 : (sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -dq : dq;
  assign r_fin = state == IDLE ? dividend : (sgn && a_q[WIDTH-1]) ? -rem : rem;
  assign ovf_fin = state == IDLE ||
                   (sgn && a_q == {1'b1, {(WIDTH-1){1'b0}}} && b_q == '1);
  alu_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem    (rem),
    .bit_in (dq[WIDTH-1]),
    .dvs    (dvs),
    .rem_nx (rem_nx),
    .q_bit  (q_bit)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !start ? IDLE : div0 ? DONE : DIVIDE;
      DIVIDE:  state_nx = cnt == '0 ? FIXUP : DIVIDE;
      FIXUP:   state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      zero_out <= 1'b0;
      negative_out <= 1'b0;
      overflow_out <= 1'b0;
      op <= '0;
      a_q <= '0;
      b_q <= '0;
      dq <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
    end else begin
      busy <= state_nx == DIVIDE || state_nx == FIXUP;
      done <= state_nx == DONE;
      if (accept) begin
        op <= alu_code(signed_op);
        a_q <= dividend;
        b_q <= divisor;
        dq <= mag_a;
        dvs <= mag_b;
        rem <= '0;
        cnt <= CW'(WIDTH - 1);
      end
      if (state == DIVIDE) begin
        rem <= rem_nx;
        dq <= {dq[WIDTH-2:0], q_bit};
        cnt <= cnt - 1'b1;
      end
      if (state_nx == DONE) begin
        quotient <= q_fin;
        remainder <= r_fin;
        zero_out <= q_fin == '0;
        negative_out <= q_fin[WIDTH-1];
        overflow_out <= ovf_fin;
      end
    end
  end
endmodule

// File: tb/tb_alu_divider.sv
// tb_alu_divider: directed + random scoreboard bench for alu_divider
module tb_alu_divider;
  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    logic        n;
    logic        o;
    int          lat;
  } exp_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic signed_op = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic busy, done, zero_out, negative_out, overflow_out, carry_out;
  logic [15:0] quotient, remainder;
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  exp_t sb[$];
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  alu_divider #(.WIDTH(16)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .signed_op    (signed_op),
    .dividend     (dividend),
    .divisor      (divisor),
    .busy         (busy),
    .done         (done),
    .quotient     (quotient),
    .remainder    (remainder),
    .zero_out     (zero_out),
    .negative_out (negative_out),
    .overflow_out (overflow_out),
    .carry_out    (carry_out)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  function automatic exp_t mk(input logic [15:0] q, input logic [15:0] r, input logic o, input int lat);
    exp_t e;
    e.q = q;
    e.r = r;
    e.z = q == 16'h0;
    e.n = q[15];
    e.o = o;
    e.lat = lat;
    return e;
  endfunction
  function automatic exp_t model(input logic s, input logic [15:0] a, input logic [15:0] b);
    int qi, ri;
    if (b == 16'h0) return mk(16'hFFFF, a, 1'b1, 1);
    if (s) begin
      qi = int'($signed(a)) / int'($signed(b));
      ri = int'($signed(a)) % int'($signed(b));
      return mk(qi[15:0], ri[15:0], qi > 32767, 18);
    end
    qi = int'(a) / int'(b);
    ri = int'(a) % int'(b);
    return mk(qi[15:0], ri[15:0], 1'b0, 18);
  endfunction
  task automatic start_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                          input exp_t e, input bit rel);
    @(negedge clock);
    start = 1'b1;
    signed_op = s;
    dividend = a;
    divisor = b;
    if (rel) reset_n = 1'b1;
    @(posedge clock);
    #1;
    acc_cyc = cyc;
    start = 1'b0;
    signed_op = ~s;
    dividend = 16'($urandom);
    divisor = 16'($urandom);
    sb.push_back(e);
  endtask
  task automatic finish_op(input string tag);
    exp_t e;
    bit seen = 0;
    int lat = 0;
    e = sb.pop_front();
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clock);
      if (k == 0) chk({tag, ".busy"}, 32'(busy), 32'(e.lat != 1));
      if (done) begin
        seen = 1;
        lat = cyc - acc_cyc + 1;
      end
    end
    chk({tag, ".done_seen"}, 32'(seen), 32'd1);
    chk({tag, ".latency"}, lat, e.lat);
    chk({tag, ".quotient"}, 32'(quotient), 32'(e.q));
    chk({tag, ".remainder"}, 32'(remainder), 32'(e.r));
    chk({tag, ".zero"}, 32'(zero_out), 32'(e.z));
    chk({tag, ".negative"}, 32'(negative_out), 32'(e.n));
    chk({tag, ".overflow"}, 32'(overflow_out), 32'(e.o));
    chk({tag, ".carry"}, 32'(carry_out), 32'd0);
    @(negedge clock);
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    chk({tag, ".hold_q"}, 32'(quotient), 32'(e.q));
  endtask
  task automatic chk_cleared(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".quotient"}, 32'(quotient), 32'd0);
    chk({tag, ".remainder"}, 32'(remainder), 32'd0);
    chk({tag, ".flags"}, {29'd0, zero_out, negative_out, overflow_out}, 32'd0);
  endtask
  initial begin
    logic s;
    logic [15:0] a, b;
    repeat (2) @(negedge clock);
    chk_cleared("reset");
    start_op(1'b0, 16'd1000, 16'd7, mk(16'd142, 16'd6, 1'b0, 18), 1'b1);
    finish_op("u1000_7");
    start_op(1'b1, 16'hFFF9, 16'd2, mk(16'hFFFD, 16'hFFFF, 1'b0, 18), 1'b0);
    finish_op("s-7_2");
    start_op(1'b1, 16'd7, 16'hFFFE, mk(16'hFFFD, 16'd1, 1'b0, 18), 1'b0);
    finish_op("s7_-2");
    start_op(1'b0, 16'd1234, 16'd0, mk(16'hFFFF, 16'd1234, 1'b1, 1), 1'b0);
    finish_op("u_div0");
    start_op(1'b1, 16'd1234, 16'd0, mk(16'hFFFF, 16'd1234, 1'b1, 1), 1'b0);
    finish_op("s_div0");
    start_op(1'b1, 16'h8000, 16'hFFFF, mk(16'h8000, 16'h0000, 1'b1, 18), 1'b0);
    finish_op("s_ovf");
    start_op(1'b0, 16'h8000, 16'hFFFF, mk(16'h0000, 16'h8000, 1'b0, 18), 1'b0);
    finish_op("u_8000");
    for (int i = 0; i < 6; i++) begin
      s = 1'($urandom);
      a = 16'($urandom);
      b = 16'($urandom_range(1, 300));
      if (i[0]) b = -b;
      start_op(s, a, b, model(s, a, b), 1'b0);
      finish_op($sformatf("rand%0d", i));
    end
    start_op(1'b0, 16'd1000, 16'd7, mk(16'd142, 16'd6, 1'b0, 18), 1'b0);
    repeat (4) @(negedge clock);
    start = 1'b1;
    signed_op = 1'b1;
    dividend = 16'd5;
    divisor = 16'd1;
    @(negedge clock);
    start = 1'b0;
    finish_op("stray_start");
    start_op(1'b0, 16'd500, 16'd3, mk(16'd166, 16'd2, 1'b0, 18), 1'b0);
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk_cleared("mid_reset");
    sb.delete();
    start_op(1'b1, 16'hFF9C, 16'd7, model(1'b1, 16'hFF9C, 16'd7), 1'b1);
    finish_op("after_reset");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_divider.md
ALU_DIVIDER -- requirements
Module: alu_divider

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset: clock  input  1  rising-edge clock for all state.
REQ-002 reset_n  input  1  asynchronous active-low reset.
REQ-003 WIDTH parameter, default 16, operand and result width; all widths below are WIDTH.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 signed_op  input  1  1 = two's-complement divide (ALU code 5'h11), 0 = unsigned (ALU code 5'h10).
REQ-006 dividend  input  16  numerator; divisor  input  16  denominator; both captured on accepted start.
REQ-007 busy  output  1  high from the cycle after accept until done.
REQ-008 done  output  1  one-cycle pulse; results valid that cycle and held until the next accept.
REQ-009 quotient  output  16; remainder  output  16.
REQ-010 zero_out  output  1  quotient == 0; negative_out  output  1  quotient[15]; overflow_out  output  1  divide-by-zero or signed overflow; carry_out  output  1  constant 0.

Function
REQ-011 States SHALL be IDLE, DIVIDE, FIXUP, DONE; DONE returns to IDLE unconditionally next cycle.
REQ-012 IDLE with start=1 SHALL capture operands and signed_op, load magnitudes (two's-complement absolute value when signed_op, raw otherwise) and enter DIVIDE with bit counter = 15.
REQ-013 DIVIDE SHALL perform one restoring shift-subtract step per cycle, MSB first, for exactly 16 cycles, then enter FIXUP.
REQ-014 FIXUP SHALL negate quotient when signed_op and dividend[15]^divisor[15], negate remainder when signed_op and dividend[15]; remainder sign follows dividend (truncating division).
REQ-015 done SHALL assert in DONE: latency from start-accept edge to done = 18 cycles for nonzero divisor.
REQ-016 Divisor == 0 SHALL bypass DIVIDE/FIXUP: IDLE -> DONE, done 1 cycle after accept, quotient 16'hFFFF, remainder = dividend unmodified, overflow_out = 1.
REQ-017 Signed 16'h8000 / 16'hFFFF SHALL run the normal path and yield quotient 16'h8000, remainder 0, overflow_out = 1.
REQ-018 Magnitude of 16'h8000 SHALL be treated as unsigned 32768 (17-bit-safe internal arithmetic), never saturated.
REQ-019 start while busy or in DONE SHALL be ignored; no queuing.
REQ-020 Operand inputs changing after accept SHALL not affect the result.
REQ-021 zero_out, negative_out, overflow_out SHALL be registered with quotient and change only in the cycle done asserts.

Reset
REQ-022 reset_n low SHALL force IDLE immediately, abort any operation in progress, and clear busy, done, quotient, remainder, all flags and counter to 0.
REQ-023 First start after reset_n release SHALL be accepted on the first rising edge with reset_n high.

Structure
REQ-024 A shared package SHALL hold the state enum, WIDTH default, and ALU codes ALU_DIV_U = 5'h10 and ALU_DIV_S = 5'h11.
REQ-025 A single-step sub-module div_step (shift, trial subtract, restore, quotient-bit out) is natural; negation/abs SHALL be inline.

Verification
REQ-026 Unsigned 1000 / 7 -> done at cycle 18, quotient 142, remainder 6, flags zero=0 neg=0 ovf=0.
REQ-027 Signed -7 (16'hFFF9) / 2 -> quotient 16'hFFFD (-3), remainder 16'hFFFF (-1), negative_out=1; and 7 / -2 -> quotient -3, remainder 1.
REQ-028 Divide by zero: 1234 / 0 (either mode) -> done 1 cycle after accept, quotient 16'hFFFF, remainder 1234, overflow_out=1.
REQ-029 Signed 16'h8000 / 16'hFFFF -> quotient 16'h8000, remainder 0, overflow_out=1; unsigned 16'h8000 / 16'hFFFF -> quotient 0, remainder 16'h8000, zero_out=1, overflow_out=0.
REQ-030 Pulse start again during DIVIDE with different operands -> ignored, first result unchanged; then assert reset_n low mid-DIVIDE -> all outputs 0 immediately, next start completes correctly in 18 cycles.
